// File: rtl/sdram_phase_sweep_if.sv
// sdram_phase_sweep_if: control/status bundle between the memtest top and
// the SDRAM PLL phase calibrator.
interface sdram_phase_sweep_if #(
  parameter int STEPS = 64
);
  logic             start;
  logic [31:0]      failcount;
  logic             phasedir;
  logic             phasestep;
  logic             phaseloadreg;
  logic             busy;
  logic             done;
  logic             fail;
  logic [7:0]       phase;
  logic [STEPS-1:0] pass_map;
  logic [7:0]       best_len;

  modport master (
    output start, failcount,
    input  phasedir, phasestep, phaseloadreg,
    input  busy, done, fail, phase, pass_map, best_len
  );

  modport slave (
    input  start, failcount,
    output phasedir, phasestep, phaseloadreg,
    output busy, done, fail, phase, pass_map, best_len
  );
endinterface

// File: rtl/sdram_phase_sweep.sv
// sdram_phase_sweep: sweeps SDRAM PLL phase, parks mid longest pass window.
// Define SDRAM_PHASE_SWEEP_WRAP_EN to detect windows across the 360 deg wrap.
module sdram_phase_sweep #(
  parameter int STEPS     = 64,
  parameter int STEP_HOLD = 4,
  parameter int SETTLE    = 1024,
  parameter int WINDOW    = 1000000
) (
  input  logic               clk,
  input  logic               rst_n,
  sdram_phase_sweep_if.slave bus
);
  localparam int IW = $clog2(STEPS);
`ifdef SDRAM_PHASE_SWEEP_WRAP_EN
  localparam int SCAN = 2 * STEPS;
`else
  localparam int SCAN = STEPS;
`endif
  localparam logic [7:0]    LAST      = 8'(STEPS - 1);
  localparam logic [7:0]    FULL      = 8'(STEPS);
  localparam logic [IW-1:0] PLAST     = IW'(STEPS - 1);
  localparam logic [8:0]    SCAN_LAST = 9'(SCAN - 1);
  localparam logic [8:0]    NSTEP     = 9'(STEPS);

  typedef enum logic [3:0] {
    S_IDLE, S_PULSE_HI, S_PULSE_LO, S_SETTLE, S_SNAP,
    S_MEASURE, S_ANALYZE, S_MOVE, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [31:0]      cnt, f0;
  logic [7:0]       idx, phase, best_len, cur_len;
  logic [IW-1:0]    pos, cur_start, best_start;
  logic [8:0]       scan;
  logic             moving, fail, accept;
  logic [STEPS-1:0] pass_map;
  logic [7:0]       nlen, target;
  logic [IW-1:0]    nstart;
  logic [8:0]       tsum;

  function automatic logic [31:0] dur(input state_t s);
    case (s)
      S_PULSE_HI, S_PULSE_LO: dur = 32'(STEP_HOLD - 1);
      S_SETTLE:               dur = 32'(SETTLE - 1);
      S_MEASURE:              dur = 32'(WINDOW - 1);
      default:                dur = '0;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      S_IDLE, S_DONE:
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = S_SETTLE;
        end
      S_PULSE_HI:
        if (cnt == 32'd0) state_nxt = S_PULSE_LO;
      S_PULSE_LO:
        if (cnt == 32'd0) state_nxt = moving ? S_MOVE : S_SETTLE;
      S_SETTLE:
        if (cnt == 32'd0) state_nxt = S_SNAP;
      S_SNAP:
        state_nxt = S_MEASURE;
      S_MEASURE:
        if (cnt == 32'd0)
          state_nxt = (idx == LAST) ? S_ANALYZE : S_PULSE_HI;
      S_ANALYZE:
        if (scan == SCAN_LAST) state_nxt = S_MOVE;
      S_MOVE:
        state_nxt = (phase == target) ? S_DONE : S_PULSE_HI;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  // Run tracking: length saturates so an all-pass wrap scan stays at STEPS.
  always_comb begin
    nlen   = 8'd0;
    nstart = (cur_len == 8'd0) ? pos : cur_start;
    if (pass_map[pos])
      nlen = (cur_len == FULL) ? FULL : cur_len + 8'd1;
    tsum   = 9'(best_start) + 9'(best_len[7:1]);
    target = (tsum >= NSTEP) ? 8'(tsum - NSTEP) : tsum[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      f0         <= '0;
      idx        <= '0;
      phase      <= '0;
      best_len   <= '0;
      cur_len    <= '0;
      pos        <= '0;
      cur_start  <= '0;
      best_start <= '0;
      scan       <= '0;
      moving     <= 1'b0;
      fail       <= 1'b0;
      pass_map   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= dur(state_nxt);
      else if (cnt != 32'd0)  cnt <= cnt - 32'd1;
      if (accept) begin
        idx      <= '0;
        pass_map <= '0;
        best_len <= '0;
        fail     <= 1'b0;
        moving   <= 1'b0;
      end
      if (state == S_PULSE_LO && cnt == 32'd0)
        phase <= (phase == LAST) ? 8'd0 : phase + 8'd1;
      if (state == S_SNAP) f0 <= bus.failcount;
      if (state == S_MEASURE && cnt == 32'd0) begin
        pass_map[phase[IW-1:0]] <= (bus.failcount == f0);
        idx        <= idx + 8'd1;
        scan       <= '0;
        pos        <= '0;
        cur_len    <= '0;
        cur_start  <= '0;
        best_start <= '0;
        best_len   <= '0;
      end
      if (state == S_ANALYZE) begin
        scan      <= scan + 9'd1;
        pos       <= (pos == PLAST) ? '0 : pos + IW'(1);
        cur_len   <= nlen;
        cur_start <= nstart;
        if (nlen > best_len) begin
          best_len   <= nlen;
          best_start <= nstart;
        end
      end
      if (state == S_MOVE) begin
        moving <= 1'b1;
        if (phase == target) fail <= (best_len == 8'd0);
      end
    end
  end

  assign bus.phasedir     = 1'b0;
  assign bus.phaseloadreg = 1'b0;
  assign bus.phasestep    = (state == S_PULSE_HI);
  assign bus.busy         = (state != S_IDLE) && (state != S_DONE);
  assign bus.done         = (state == S_DONE);
  assign bus.fail         = fail;
  assign bus.phase        = phase;
  assign bus.pass_map     = pass_map;
  assign bus.best_len     = best_len;
endmodule

// File: doc/sdram_phase_sweep.md
Name: sdram_phase_sweep

Overview:
- Automatic SDRAM clock-phase calibrator; takes the place of the manual button phase stepper in the memtest top.
- Drives the dynamic-phase inputs of the SDRAM ecp5pll (phasesel fixed to out1 at top level) and consumes mem_tester failcount.
- Sweeps every phase step, classifies each step as pass or fail, then parks the PLL in the middle of the longest passing window.

Parameters:
- STEPS, 64, phase steps per full 360 deg of the PLL output; the phase index wraps after STEPS steps; 4..255.
- STEP_HOLD, 4, cycles phasestep is held high, then low, per step pulse.
- SETTLE, 1024, cycles waited after each step before measuring.
- WINDOW, 1000000, measurement cycles per step.

Ports:
- clk  in  1  system clock; failcount must already be synchronous to clk (CDC is done at top level).
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a sweep.
- failcount  in  32  cumulative error count from mem_tester.
- phasedir  out  1  PLL phase direction; always 0 (advance).
- phasestep  out  1  PLL step strobe, active high.
- phaseloadreg  out  1  always 0.
- busy  out  1  high while sweeping or moving.
- done  out  1  high when calibration has finished.
- fail  out  1  high when no step passed.
- phase  out  8  current phase index relative to the PLL reset position.
- pass_map  out  STEPS  bit i = 1 when step i passed.
- best_len  out  8  length of the chosen passing run.

Behaviour:
- Reset values: all outputs 0, state IDLE. rst_n must be asserted together with any PLL reset so that phase 0 matches the PLL reset position. A reset mid-sweep drops phasestep on the next edge; the PLL phase is not restored.
- States: IDLE, PULSE_HI, PULSE_LO, SETTLE, SNAP, MEASURE, ANALYZE, MOVE, DONE.
- start is accepted only in IDLE or DONE. Acceptance clears done, fail, pass_map and best_len, sets busy and sets idx=0. start is ignored while busy.
- Measurement:
  - For idx 0, go directly to SETTLE (no pulse).
  - For idx > 0, issue one step pulse: PULSE_HI (phasestep=1 for STEP_HOLD cycles), then PULSE_LO (phasestep=0 for STEP_HOLD cycles). phase increments modulo STEPS on leaving PULSE_LO.
  - SETTLE lasts SETTLE cycles. SNAP latches f0=failcount for 1 cycle. MEASURE lasts WINDOW cycles.
  - At the end of MEASURE, pass_map[idx] = (failcount == f0). Compare by 32-bit equality, so a counter wrap still counts as a fail.
  - idx then increments. After idx == STEPS-1, go to ANALYZE.
- ANALYZE:
  - One map index per cycle, i = 0..STEPS-1, tracking the current run start and length.
  - best is replaced only when cur_len > best_len, so the earliest (lowest start) longest run wins ties.
  - target = (best_start + best_len/2) mod STEPS, floor division.
- MOVE:
  - At entry phase = STEPS-1.
  - Issue (target - phase) mod STEPS pulses using the same PULSE_HI/PULSE_LO timing, then go to DONE.
  - If best_len == 0: fail=1 and target=0, so 1 pulse is issued.
- DONE: busy=0, done=1. phase == target and stays constant until the next start.

Optional Feature:
- SDRAM_PHASE_SWEEP_WRAP_EN
  - Defined: ANALYZE scans i = 0..2*STEPS-1 over pass_map[i mod STEPS], so runs spanning STEPS-1 to 0 are detected. Run length saturates at STEPS and best_start is taken mod STEPS. An all-pass map gives best_start=0, best_len=STEPS.
  - Undefined: linear scan only; no run crosses the wrap point.

Test Plan:
(bench parameters STEPS=8, STEP_HOLD=2, SETTLE=4, WINDOW=16; the failcount model increments during MEASURE on fail steps)
- Fail steps {0,1,6,7}, start pulse -> pass_map=8'b00111100, best_len=4, target 4. Expect 7 sweep pulses, then 5 move pulses, then done=1, phase=4, fail=0.
- All steps fail -> fail=1, done=1, best_len=0, 1 move pulse, phase=0.
- Pass only steps {0,1,7}:
  - Without WRAP_EN: best_len=2, final phase=1, 2 move pulses.
  - With WRAP_EN: best_len=3, best_start=7, final phase=0, 1 move pulse.
- Pass only steps {0,1,4,5} (tie) -> earliest run wins, best_len=2, final phase=1.
- All steps pass -> best_len=8, final phase=4. Then a second start from DONE repeats the sweep with identical results and relative pulse counts.
- Assert start while in MEASURE -> ignored, results unchanged. Assert rst_n=0 in MEASURE -> next edge: busy=0, done=0, phasestep=0, phase=0, pass_map=0.
